// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA layer compositor:
//   - cfg_field codes used on the configuration write port
//   - 640x480 screen constants
//   - layer_cfg_t: one layer's window / visibility configuration
// ---------------------------------------------------------------------------
package vga_pkg;

  // Configuration field selectors (cfg_field)
  localparam logic [2:0] CFG_X0    = 3'd0;
  localparam logic [2:0] CFG_Y0    = 3'd1;
  localparam logic [2:0] CFG_W     = 3'd2;
  localparam logic [2:0] CFG_H     = 3'd3;
  localparam logic [2:0] CFG_MASK  = 3'd4;
  localparam logic [2:0] CFG_BLINK = 3'd5;
  localparam logic [2:0] CFG_BG    = 3'd6;

  // Visible screen area driven by vga_driver
  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;

  // Coordinate / window register width
  localparam int unsigned COORD_W = 10;

  // Visibility mask width: one bit per menu/game state (2**3 states)
  localparam int unsigned MASK_W = 8;

  typedef struct packed {
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [MASK_W-1:0]  mask;
    logic               blink_en;
  } layer_cfg_t;

endpackage

// File: rtl/vga_layer_addr.sv
// ---------------------------------------------------------------------------
// vga_layer_addr
// One image layer: shadow/active configuration registers, window compare,
// visibility and ROM address generation (S1), plus a one-cycle delay of the
// visibility flag so it lines up with the ROM's registered output (S2).
//
// Ports
//   clk, rst          pixel clock, asynchronous active-low reset
//   cfg_we            write strobe, already decoded for this layer
//   cfg_field/data    field select and write data (shadow copy only)
//   commit            frame-start strobe: active <= shadow
//   blink_phase       global blink phase (1 = blinking layers hidden)
//   next_x, next_y    pixel coordinate being sampled
//   state             current menu/game state
//   rom_addr          registered ROM read address (0 when not visible)
//   vis_p2            visibility aligned with the ROM data
// ---------------------------------------------------------------------------
module vga_layer_addr
  import vga_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [2:0]         cfg_field,
  input  logic [COORD_W-1:0] cfg_data,
  input  logic               commit,
  input  logic               blink_phase,
  input  logic [COORD_W-1:0] next_x,
  input  logic [COORD_W-1:0] next_y,
  input  logic [STATE_W-1:0] state,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               vis_p2
);

  layer_cfg_t shadow;
  layer_cfg_t active;

  // Writes land in the shadow copy; the active copy only changes at the
  // frame boundary so a frame is never drawn with a half-updated window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow <= '0;
      active <= '0;
    end else begin
      if (cfg_we) begin
        case (cfg_field)
          CFG_X0:    shadow.x0       <= cfg_data;
          CFG_Y0:    shadow.y0       <= cfg_data;
          CFG_W:     shadow.w        <= cfg_data;
          CFG_H:     shadow.h        <= cfg_data;
          CFG_MASK:  shadow.mask     <= cfg_data[MASK_W-1:0];
          CFG_BLINK: shadow.blink_en <= cfg_data[0];
          default:   ;
        endcase
      end
      if (commit) begin
        active <= shadow;
      end
    end
  end

  logic [COORD_W:0]   x_end;
  logic [COORD_W:0]   y_end;
  logic               in_x;
  logic               in_y;
  logic               mask_hit;
  logic               blink_ok;
  logic               vis_p0;
  logic [COORD_W-1:0] dx;
  logic [COORD_W-1:0] dy;
  logic [ADDR_W-1:0]  addr_p0;
  logic               vis_p1;

  always_comb begin
    // 11-bit window ends so x0+w beyond 1023 cannot wrap to small x.
    // w=0 (or h=0) makes the range empty without a special case.
    x_end    = {1'b0, active.x0} + {1'b0, active.w};
    y_end    = {1'b0, active.y0} + {1'b0, active.h};
    in_x     = ({1'b0, next_x} >= {1'b0, active.x0}) && ({1'b0, next_x} < x_end);
    in_y     = ({1'b0, next_y} >= {1'b0, active.y0}) && ({1'b0, next_y} < y_end);
    mask_hit = |(active.mask & (MASK_W'(1) << state));
    blink_ok = !active.blink_en || !blink_phase;
    vis_p0   = in_x && in_y && mask_hit && blink_ok;
    dx       = next_x - active.x0;
    dy       = next_y - active.y0;
    // Computing in ADDR_W bits gives the product modulo 2**ADDR_W directly.
    addr_p0  = ADDR_W'(dy) * ADDR_W'(active.w) + ADDR_W'(dx);
  end

  // ---- S1: window compare / address register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vis_p1   <= 1'b0;
      rom_addr <= '0;
    end else begin
      vis_p1   <= vis_p0;
      rom_addr <= vis_p0 ? addr_p0 : '0;
    end
  end

  // ---- S2: visibility delayed alongside the ROM read ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vis_p2 <= 1'b0;
    end else begin
      vis_p2 <= vis_p1;
    end
  end

endmodule

// File: rtl/vga_layer_compositor.sv
// ---------------------------------------------------------------------------
// vga_layer_compositor
// Composites N_LAYERS ROM-backed image windows onto the VGA pixel stream.
// Lower layer index has higher priority; pixels equal to KEY_COLOR fall
// through to the next layer, and bg_color is shown where nothing qualifies.
// Configuration is written to shadow registers and committed at frame start.
// Pixel latency from next_x/next_y to color_out is 3 cycles.
//
// Ports
//   clk, rst          25 MHz pixel clock, asynchronous active-low reset
//   next_x, next_y    pixel coordinate from vga_driver
//   state             current menu/game state (selects visibility mask bit)
//   cfg_we            configuration write strobe
//   cfg_layer         target layer (writes to layers >= N_LAYERS ignored)
//   cfg_field         0=x0 1=y0 2=w 3=h 4=state_mask 5=blink_en 6=bg_color
//   cfg_data          write data, low bits used
//   rom_addr          flattened per-layer ROM addresses, layer i at i*ADDR_W
//   rom_q             flattened per-layer ROM data (1-cycle read latency)
//   color_out         composited pixel to vga_driver.color_in
//   frame_start       one-cycle pulse, 1 cycle after (0,0) is sampled
// ---------------------------------------------------------------------------
module vga_layer_compositor
  import vga_pkg::*;
#(
  parameter int                 N_LAYERS     = 4,
  parameter int                 ADDR_W       = 16,
  parameter int                 COLOR_W      = 8,
  parameter int                 STATE_W      = 3,
  parameter logic [COLOR_W-1:0] KEY_COLOR    = '0,
  parameter int                 BLINK_FRAMES = 30
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COORD_W-1:0]           next_x,
  input  logic [COORD_W-1:0]           next_y,
  input  logic [STATE_W-1:0]           state,
  input  logic                         cfg_we,
  input  logic [7:0]                   cfg_layer,
  input  logic [2:0]                   cfg_field,
  input  logic [COORD_W-1:0]           cfg_data,
  output logic [N_LAYERS*ADDR_W-1:0]   rom_addr,
  input  logic [N_LAYERS*COLOR_W-1:0]  rom_q,
  output logic [COLOR_W-1:0]           color_out,
  output logic                         frame_start
);

  localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic               coord_zero;
  logic               prev_zero;
  logic               frame_hit;
  logic [CNT_W-1:0]   frame_cnt;
  logic               blink_phase;
  logic [COLOR_W-1:0] bg_shadow;
  logic [COLOR_W-1:0] bg_active;
  logic [N_LAYERS-1:0] vis_p2;
  logic [COLOR_W-1:0] color_sel;

  // Frame start is the (0,0) coordinate following any other coordinate.
  // prev_zero resets to 0 so the first (0,0) after reset is a frame start.
  assign coord_zero = (next_x == '0) && (next_y == '0);
  assign frame_hit  = coord_zero && !prev_zero;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_zero   <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
      bg_shadow   <= '0;
      bg_active   <= '0;
    end else begin
      prev_zero   <= coord_zero;
      frame_start <= frame_hit;
      if (frame_hit) begin
        if (frame_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
          frame_cnt   <= '0;
          blink_phase <= !blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
        bg_active <= bg_shadow;
      end
      if (cfg_we && (cfg_field == CFG_BG)) begin
        bg_shadow <= COLOR_W'(cfg_data);
      end
    end
  end

  for (genvar i = 0; i < N_LAYERS; i++) begin : g_layer
    logic layer_we;
    assign layer_we = cfg_we && (cfg_field != CFG_BG) && (cfg_layer == 8'(i));

    vga_layer_addr #(
      .ADDR_W (ADDR_W),
      .STATE_W(STATE_W)
    ) u_layer (
      .clk        (clk),
      .rst        (rst),
      .cfg_we     (layer_we),
      .cfg_field  (cfg_field),
      .cfg_data   (cfg_data),
      .commit     (frame_hit),
      .blink_phase(blink_phase),
      .next_x     (next_x),
      .next_y     (next_y),
      .state      (state),
      .rom_addr   (rom_addr[i*ADDR_W +: ADDR_W]),
      .vis_p2     (vis_p2[i])
    );
  end

  // Walk from lowest to highest priority so the lowest-index qualifying
  // layer is the last assignment and wins.
  always_comb begin
    color_sel = bg_active;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (vis_p2[i] && (rom_q[i*COLOR_W +: COLOR_W] != KEY_COLOR)) begin
        color_sel = rom_q[i*COLOR_W +: COLOR_W];
      end
    end
  end

  // ---- S3: priority / key select register ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      color_out <= '0;
    end else begin
      color_out <= color_sel;
    end
  end

endmodule

// File: tb/tb_vga_layer_compositor.sv
// ---------------------------------------------------------------------------
// tb_vga_layer_compositor
// Directed testbench for vga_layer_compositor. The bench models the image
// ROMs as rom_q[i] <= rom_const[i] ^ rom_addr[i][7:0] (1-cycle latency), so
// colour checks also cover the address arithmetic.
// ---------------------------------------------------------------------------
module tb_vga_layer_compositor;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int CW = 8;
  localparam int SW = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic [9:0]        next_x;
  logic [9:0]        next_y;
  logic [SW-1:0]     state;
  logic              cfg_we;
  logic [7:0]        cfg_layer;
  logic [2:0]        cfg_field;
  logic [9:0]        cfg_data;
  logic [N*AW-1:0]   rom_addr;
  logic [N*CW-1:0]   rom_q = '0;
  logic [CW-1:0]     color_out;
  logic              frame_start;

  logic [7:0]        rom_const [N];
  int                n_checks = 0;
  int                n_fail   = 0;

  vga_layer_compositor #(
    .N_LAYERS    (N),
    .ADDR_W      (AW),
    .COLOR_W     (CW),
    .STATE_W     (SW),
    .KEY_COLOR   (8'h00),
    .BLINK_FRAMES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .next_x     (next_x),
    .next_y     (next_y),
    .state      (state),
    .cfg_we     (cfg_we),
    .cfg_layer  (cfg_layer),
    .cfg_field  (cfg_field),
    .cfg_data   (cfg_data),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .color_out  (color_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      rom_q[i*CW +: CW] <= rom_const[i] ^ rom_addr[i*AW +: 8];
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_px(input int x, input int y);
    @(negedge clk);
    next_x = 10'(x);
    next_y = 10'(y);
  endtask

  // Drive a coordinate and hold it until its colour has reached color_out.
  task automatic hold_px(input int x, input int y);
    set_px(x, y);
    repeat (3) @(negedge clk);
  endtask

  task automatic cfg_write(input int l, input int f, input int d);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_layer = 8'(l);
    cfg_field = 3'(f);
    cfg_data  = 10'(d);
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  task automatic frame();
    set_px(1, 1);
    set_px(0, 0);
    set_px(1, 1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0; cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_data = '0;
    next_x = 10'd5; next_y = 10'd5; state = 3'd3;
    for (int i = 0; i < N; i++) rom_const[i] = 8'hA5;
    repeat (3) @(negedge clk);
    n_checks++;
    if (color_out !== 8'h00) begin n_fail++; $display("FAIL reset_color: got %h want 00", color_out); end
    n_checks++;
    if (rom_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", rom_addr); end
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_fs: got %b want 0", frame_start); end
    @(negedge clk);
    rst = 1'b1;
    set_px(0, 0);
    @(negedge clk);
    n_checks++;
    if (frame_start !== 1'b1) begin n_fail++; $display("FAIL first_frame_start: got %b want 1", frame_start); end
    @(negedge clk);
    n_checks++;
    if (frame_start !== 1'b0) begin n_fail++; $display("FAIL fs_one_cycle: got %b want 0", frame_start); end
    for (int y = 0; y < 480; y += 60) begin
      for (int x = 0; x < 640; x += 91) begin
        hold_px(x, y);
        n_checks++;
        if (color_out !== 8'h00 || rom_addr !== '0) begin
          n_fail++;
          $display("FAIL reset_sweep (%0d,%0d): color %h addr %h want 00 / 0", x, y, color_out, rom_addr);
        end
      end
    end
  endtask

  task automatic test_single_layer();
    cfg_write(0, 0, 200);
    cfg_write(0, 1, 120);
    cfg_write(0, 2, 240);
    cfg_write(0, 3, 240);
    cfg_write(0, 4, 8);
    cfg_write(0, 6, 7);
    rom_const[0] = 8'h11;
    frame();
    repeat (3) @(negedge clk);
    n_checks++;
    if (color_out !== 8'h07) begin n_fail++; $display("FAIL single_bg_before: got %h want 07", color_out); end
    set_px(201, 121);
    @(negedge clk);
    n_checks++;
    if (rom_addr[AW-1:0] !== 16'd241) begin n_fail++; $display("FAIL single_addr_lat1: got %0d want 241", rom_addr[AW-1:0]); end
    @(negedge clk);
    n_checks++;
    if (color_out !== 8'h07) begin n_fail++; $display("FAIL single_color_early: got %h want 07", color_out); end
    @(negedge clk);
    n_checks++;
    if (color_out !== 8'hE0) begin n_fail++; $display("FAIL single_color_lat3: got %h want e0", color_out); end
    hold_px(440, 121);
    n_checks++;
    if (color_out !== 8'h07 || rom_addr[AW-1:0] !== 16'd0) begin
      n_fail++; $display("FAIL single_right_edge: color %h addr %0d want 07 / 0", color_out, rom_addr[AW-1:0]);
    end
    hold_px(199, 121);
    n_checks++;
    if (color_out !== 8'h07) begin n_fail++; $display("FAIL single_left_edge: got %h want 07", color_out); end
    hold_px(439, 359);
    n_checks++;
    if (color_out !== 8'hEE || rom_addr[AW-1:0] !== 16'd57599) begin
      n_fail++; $display("FAIL single_last_px: color %h addr %0d want ee / 57599", color_out, rom_addr[AW-1:0]);
    end
    hold_px(200, 360);
    n_checks++;
    if (color_out !== 8'h07) begin n_fail++; $display("FAIL single_bottom_edge: got %h want 07", color_out); end
  endtask

  task automatic test_priority_key();
    cfg_write(1, 0, 210);
    cfg_write(1, 1, 130);
    cfg_write(1, 2, 50);
    cfg_write(1, 3, 50);
    cfg_write(1, 4, 8);
    frame();
    rom_const[0] = 8'h6A;
    rom_const[1] = 8'h5A;
    hold_px(210, 130);
    n_checks++;
    if (rom_addr[AW-1:0] !== 16'd2410 || rom_addr[2*AW-1:AW] !== 16'd0) begin
      n_fail++; $display("FAIL prio_addrs: l0 %0d l1 %0d want 2410 / 0", rom_addr[AW-1:0], rom_addr[2*AW-1:AW]);
    end
    n_checks++;
    if (color_out !== 8'h5A) begin n_fail++; $display("FAIL prio_key_fallthrough: got %h want 5a", color_out); end
    rom_const[0] = 8'h6A ^ 8'h33;
    repeat (3) @(negedge clk);
    n_checks++;
    if (color_out !== 8'h33) begin n_fail++; $display("FAIL prio_layer0_wins: got %h want 33", color_out); end
    rom_const[0] = 8'h6A;
    rom_const[1] = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++;
    if (color_out !== 8'h07) begin n_fail++; $display("FAIL prio_all_keyed: got %h want 07", color_out); end
    rom_const[1] = 8'h5A;
    hold_px(260, 130);
    n_checks++;
    if (color_out !== 8'hF6) begin n_fail++; $display("FAIL prio_l1_edge: got %h want f6", color_out); end
  endtask

  task automatic test_shadow_commit();
    rom_const[0] = 8'h11;
    hold_px(250, 121);
    n_checks++;
    if (color_out !== 8'h33) begin n_fail++; $display("FAIL shadow_pre: got %h want 33", color_out); end
    cfg_write(0, 0, 300);
    hold_px(250, 121);
    n_checks++;
    if (color_out !== 8'h33) begin n_fail++; $display("FAIL shadow_not_live: got %h want 33", color_out); end
    frame();
    hold_px(250, 121);
    n_checks++;
    if (color_out !== 8'h07) begin n_fail++; $display("FAIL shadow_old_gone: got %h want 07", color_out); end
    hold_px(301, 121);
    n_checks++;
    if (color_out !== 8'hE0) begin n_fail++; $display("FAIL shadow_new_win: got %h want e0", color_out); end
    // Write issued in the same cycle that (0,0) is sampled.
    set_px(1, 1);
    @(negedge clk);
    next_x = 10'd0; next_y = 10'd0;
    cfg_we = 1'b1; cfg_layer = 8'd0; cfg_field = 3'd0; cfg_data = 10'd200;
    @(negedge clk);
    cfg_we = 1'b0;
    n_checks++;
    if (frame_start !== 1'b1) begin n_fail++; $display("FAIL shadow_fs_with_write: got %b want 1", frame_start); end
    next_x = 10'd1; next_y = 10'd1;
    hold_px(250, 121);
    n_checks++;
    if (color_out !== 8'h07) begin n_fail++; $display("FAIL shadow_same_cycle_deferred: got %h want 07", color_out); end
    frame();
    hold_px(250, 121);
    n_checks++;
    if (color_out !== 8'h33) begin n_fail++; $display("FAIL shadow_deferred_applied: got %h want 33", color_out); end
    cfg_write(4, 0, 0);
    frame();
    hold_px(250, 121);
    n_checks++;
    if (color_out !== 8'h33) begin n_fail++; $display("FAIL shadow_bad_layer_ignored: got %h want 33", color_out); end
  endtask

  task automatic test_blink();
    @(negedge clk);
    rst = 1'b0;
    next_x = 10'd5; next_y = 10'd5;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    cfg_write(2, 0, 10);
    cfg_write(2, 1, 10);
    cfg_write(2, 2, 20);
    cfg_write(2, 3, 20);
    cfg_write(2, 4, 8);
    cfg_write(2, 5, 1);
    cfg_write(0, 6, 7);
    rom_const[2] = 8'h44;
    for (int k = 1; k <= 5; k++) begin
      logic [7:0] exp_c;
      frame();
      hold_px(10, 10);
      exp_c = (((k / 2) % 2) == 0) ? 8'h44 : 8'h07;
      n_checks++;
      if (color_out !== exp_c) begin n_fail++; $display("FAIL blink_frame%0d: got %h want %h", k, color_out, exp_c); end
    end
  endtask

  task automatic test_edges();
    cfg_write(3, 0, 50);
    cfg_write(3, 1, 50);
    cfg_write(3, 2, 0);
    cfg_write(3, 3, 10);
    cfg_write(3, 4, 8);
    rom_const[3] = 8'h99;
    frame();
    hold_px(50, 50);
    n_checks++;
    if (color_out !== 8'h07 || rom_addr[4*AW-1:3*AW] !== 16'd0) begin
      n_fail++; $display("FAIL edge_w0: color %h addr %0d want 07 / 0", color_out, rom_addr[4*AW-1:3*AW]);
    end
    cfg_write(3, 0, 1000);
    cfg_write(3, 1, 0);
    cfg_write(3, 2, 100);
    frame();
    hold_px(75, 5);
    n_checks++;
    if (color_out !== 8'h07 || rom_addr[4*AW-1:3*AW] !== 16'd0) begin
      n_fail++; $display("FAIL edge_nowrap: color %h addr %0d want 07 / 0", color_out, rom_addr[4*AW-1:3*AW]);
    end
    hold_px(1023, 9);
    n_checks++;
    if (color_out !== 8'h02 || rom_addr[4*AW-1:3*AW] !== 16'd923) begin
      n_fail++; $display("FAIL edge_far_right: color %h addr %0d want 02 / 923", color_out, rom_addr[4*AW-1:3*AW]);
    end
    hold_px(1010, 5);
    n_checks++;
    if (color_out !== 8'h67 || rom_addr[4*AW-1:3*AW] !== 16'd510) begin
      n_fail++; $display("FAIL edge_hi_x: color %h addr %0d want 67 / 510", color_out, rom_addr[4*AW-1:3*AW]);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (color_out !== 8'h00 || rom_addr !== '0 || frame_start !== 1'b0) begin
      n_fail++; $display("FAIL edge_async_reset: color %h addr %h fs %b want 00 / 0 / 0", color_out, rom_addr, frame_start);
    end
    @(negedge clk);
    rst = 1'b1;
    hold_px(1010, 5);
    n_checks++;
    if (color_out !== 8'h00) begin n_fail++; $display("FAIL edge_cfg_cleared: got %h want 00", color_out); end
    set_px(0, 0);
    @(negedge clk);
    n_checks++;
    if (frame_start !== 1'b1) begin n_fail++; $display("FAIL edge_fs_after_reset: got %b want 1", frame_start); end
  endtask

  initial begin
    test_reset();
    test_single_layer();
    test_priority_key();
    test_shadow_commit();
    test_blink();
    test_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
